// File: rtl/pattern_serializer.sv
// pattern_serializer: serial bit-pattern transmitter.
// Latches a WIDTH-bit pattern on a start handshake and shifts it out MSB first,
// one bit per clk, repeated repeat_count times (0 treated as 1), with GAP idle
// cycles between repetitions.
// Optional feature macro: PATTERN_SERIALIZER_LOOP_EN adds a stop input;
// repeat_count==0 then means repeat forever, and stop ends the transfer after
// the current repetition (any pending gap is skipped).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stop                  (LOOP_EN only) finish after current repetition
//   start                 request, accepted when start && ready
//   pattern_in[WIDTH]     pattern, sampled on accept
//   repeat_count[8]       repetitions, sampled on accept
//   ready                 high only in IDLE
//   out, out_valid        serial bit and its qualifier (out=0 when not valid)
//   busy                  high in SEND and GAP
//   done                  one-cycle pulse after the final bit
module pattern_serializer #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PATTERN_SERIALIZER_LOOP_EN
  input  logic             stop,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [7:0]       repeat_count,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;   // shreg[WIDTH-1] mirrors the bit on out
  logic [WIDTH-1:0] pat, pat_n;       // latched copy, reloaded each repetition
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [7:0]       rep, rep_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic             forever_r, forever_n;
  logic             stop_flag, stop_flag_n;
  logic             out_n, valid_n, busy_n, done_n, ready_n;
  logic             stop_eff_c, more_c;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      pat       <= '0;
      bit_cnt   <= '0;
      rep       <= 8'd1;
      gap_cnt   <= '0;
      forever_r <= 1'b0;
      stop_flag <= 1'b0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      pat       <= pat_n;
      bit_cnt   <= bit_cnt_n;
      rep       <= rep_n;
      gap_cnt   <= gap_cnt_n;
      forever_r <= forever_n;
      stop_flag <= stop_flag_n;
      out       <= out_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
      ready     <= ready_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    pat_n       = pat;
    bit_cnt_n   = bit_cnt;
    rep_n       = rep;
    gap_cnt_n   = gap_cnt;
    forever_n   = forever_r;
    stop_flag_n = stop_flag;
    out_n       = 1'b0;
    valid_n     = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    ready_n     = 1'b0;
`ifdef PATTERN_SERIALIZER_LOOP_EN
    // A stop seen on the deciding edge itself counts as well as an earlier one
    stop_eff_c  = stop_flag | stop;
`else
    stop_eff_c  = stop_flag;
`endif
    more_c      = forever_r ? !stop_eff_c : ((rep > 8'd1) && !stop_eff_c);

    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        if (start) begin
          state_n     = S_SEND;
          shreg_n     = pattern_in;
          pat_n       = pattern_in;
          bit_cnt_n   = BW'(WIDTH - 1);
          rep_n       = (repeat_count == 8'd0) ? 8'd1 : repeat_count;
`ifdef PATTERN_SERIALIZER_LOOP_EN
          forever_n   = (repeat_count == 8'd0);
`else
          forever_n   = 1'b0;
`endif
          stop_flag_n = 1'b0;
          out_n       = pattern_in[WIDTH-1];
          valid_n     = 1'b1;
          busy_n      = 1'b1;
          ready_n     = 1'b0;
        end
      end

      S_SEND: begin
        stop_flag_n = stop_eff_c;
        if (bit_cnt != '0) begin
          shreg_n   = shreg << 1;
          bit_cnt_n = bit_cnt - BW'(1);
          out_n     = shreg[WIDTH-2];
          valid_n   = 1'b1;
          busy_n    = 1'b1;
        end else if (more_c) begin
          // Bit 0 is on out: start another repetition, directly or via gap
          if (!forever_r) rep_n = rep - 8'd1;
          busy_n = 1'b1;
          if (GAP == 0) begin
            shreg_n   = pat;
            bit_cnt_n = BW'(WIDTH - 1);
            out_n     = pat[WIDTH-1];
            valid_n   = 1'b1;
          end else begin
            state_n   = S_GAP;
            gap_cnt_n = GW'(GAP - 1);
          end
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          ready_n = 1'b1;
        end
      end

      S_GAP: begin
        stop_flag_n = stop_eff_c;
        if (stop_eff_c) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          ready_n = 1'b1;
        end else if (gap_cnt == '0) begin
          state_n   = S_SEND;
          shreg_n   = pat;
          bit_cnt_n = BW'(WIDTH - 1);
          out_n     = pat[WIDTH-1];
          valid_n   = 1'b1;
          busy_n    = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - GW'(1);
          busy_n    = 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: two instances (GAP=0 and GAP=2) share the same
// stimulus; each is compared every cycle against an offset-based model derived
// from the transfer schedule (period WIDTH+GAP, length rep*WIDTH+(rep-1)*GAP).
module tb_pattern_serializer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] pattern_in;
  logic [7:0]   repeat_count;
`ifdef PATTERN_SERIALIZER_LOOP_EN
  logic         stop;
`endif
  logic ra, oa, va, ba, da;
  logic rb, ob, vb, bb, db;

  int total = 0;
  int bad   = 0;

  // Model state per instance: offset into the transfer (-1 = idle)
  int           mk   [2];
  int           mtot [2];
  logic         mdone[2];
  logic [W-1:0] mpat [2];

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(W), .GAP(0)) dut_a (
    .clk(clk), .reset(reset),
`ifdef PATTERN_SERIALIZER_LOOP_EN
    .stop(stop),
`endif
    .start(start), .pattern_in(pattern_in), .repeat_count(repeat_count),
    .ready(ra), .out(oa), .out_valid(va), .busy(ba), .done(da));

  pattern_serializer #(.WIDTH(W), .GAP(2)) dut_b (
    .clk(clk), .reset(reset),
`ifdef PATTERN_SERIALIZER_LOOP_EN
    .stop(stop),
`endif
    .start(start), .pattern_in(pattern_in), .repeat_count(repeat_count),
    .ready(rb), .out(ob), .out_valid(vb), .busy(bb), .done(db));

  function automatic int gapof(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Observed outputs packed as {out, out_valid, busy, done, ready}
  function automatic logic [4:0] obs(int d);
    if (d == 0) return {oa, va, ba, da, ra};
    return {ob, vb, bb, db, rb};
  endfunction

  function automatic logic [4:0] expv(int d);
    int p;
    logic [W-1:0] pv;
    if (mk[d] < 0) return {1'b0, 1'b0, 1'b0, mdone[d], 1'b1};
    p  = mk[d] % (W + gapof(d));
    pv = mpat[d];
    if (p < W) return {pv[W-1-p], 1'b1, 1'b1, 1'b0, 1'b0};
    return 5'b00100;
  endfunction

  // Apply one clock edge to the model using the inputs the DUT sampled
  task automatic model_edge();
    int reps, per, p, nt;
    logic stp;
    stp = 1'b0;
`ifdef PATTERN_SERIALIZER_LOOP_EN
    stp = stop;
`endif
    for (int d = 0; d < 2; d++) begin
      per = W + gapof(d);
      if (reset) begin
        mk[d] = -1; mdone[d] = 1'b0;
      end else if (mk[d] < 0) begin
        mdone[d] = 1'b0;
        if (start) begin
          mpat[d] = pattern_in;
          reps    = (repeat_count == 8'd0) ? 1 : int'(repeat_count);
          mtot[d] = reps * W + (reps - 1) * gapof(d);
`ifdef PATTERN_SERIALIZER_LOOP_EN
          if (repeat_count == 8'd0) mtot[d] = 1 << 30;
`endif
          mk[d] = 0;
        end
      end else begin
        if (stp) begin
          p  = mk[d] % per;
          nt = (p < W) ? (mk[d] / per) * per + W : mk[d] + 1;
          if (nt < mtot[d]) mtot[d] = nt;
        end
        if (mk[d] + 1 < mtot[d]) mk[d] = mk[d] + 1;
        else begin mk[d] = -1; mdone[d] = 1'b1; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; pattern_in = '0; repeat_count = 8'd0;
`ifdef PATTERN_SERIALIZER_LOOP_EN
    stop = 1'b0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    if ({oa, va, ba, da, ra} !== 5'b00001) begin
      bad++; $display("FAIL reset_a got=%b exp=00001", {oa, va, ba, da, ra});
    end
    total++;
    if ({ob, vb, bb, db, rb} !== 5'b00001) begin
      bad++; $display("FAIL reset_b got=%b exp=00001", {ob, vb, bb, db, rb});
    end
    total++;
  endtask

  task automatic test_patterns();
    logic [W-1:0] pl [4];
    logic [7:0]   cl [4];
    pl = '{3'b101, 3'b110, 3'b101, 3'b011};
    cl = '{8'd1, 8'd3, 8'd2, 8'd0};
    for (int s = 0; s < 4; s++) begin
      reset = 1'b1; tick(); reset = 1'b0;
      start = 1'b1; pattern_in = pl[s]; repeat_count = cl[s];
      tick();
      start = 1'b0; pattern_in = ~pl[s];
      for (int c = 0; c < 16; c++) begin
        for (int d = 0; d < 2; d++) begin
          total++;
          if (obs(d) !== expv(d)) begin
            bad++;
            $display("FAIL pattern s%0d dut%0d c%0d got=%b exp=%b (o,v,b,d,r)",
                     s, d, c + 1, obs(d), expv(d));
          end
        end
        tick();
      end
    end
  endtask

  // start held through a transfer: ignored while busy, accepted on the done cycle
  task automatic test_back_to_back();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; repeat_count = 8'd2;
    for (int c = 0; c < 30; c++) begin
      pattern_in = W'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d)) begin
          bad++;
          $display("FAIL back_to_back dut%0d c%0d got=%b exp=%b", d, c, obs(d), expv(d));
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; pattern_in = 3'b110; repeat_count = 8'd4;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== expv(d)) begin
        bad++; $display("FAIL reset_mid dut%0d got=%b exp=%b", d, obs(d), expv(d));
      end
    end
    total++;
    if ({oa, va, ba, da, ra} !== 5'b00001) begin
      bad++; $display("FAIL reset_mid_const got=%b exp=00001", {oa, va, ba, da, ra});
    end
    tick();
    total++;
    if (da !== 1'b0) begin
      bad++; $display("FAIL reset_mid_nodone got=%b exp=0", da);
    end
  endtask

`ifdef PATTERN_SERIALIZER_LOOP_EN
  task automatic test_loop_stop();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; pattern_in = 3'b101; repeat_count = 8'd0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      stop = (c == 5);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d)) begin
          bad++; $display("FAIL loop_stop dut%0d c%0d got=%b exp=%b", d, c, obs(d), expv(d));
        end
      end
      if (c == 7) begin
        total++;
        if (da !== 1'b1) begin
          bad++; $display("FAIL loop_stop_done c7 got=%b exp=1", da);
        end
      end
      tick();
    end
    stop = 1'b0;
  endtask
`endif

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 99) == 0);
      start        = ($urandom_range(0, 2) == 0);
      pattern_in   = W'($urandom);
      repeat_count = 8'($urandom_range(0, 3));
`ifdef PATTERN_SERIALIZER_LOOP_EN
      stop         = ($urandom_range(0, 14) == 0);
`endif
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d)) begin
          bad++; $display("FAIL random dut%0d c%0d got=%b exp=%b", d, c, obs(d), expv(d));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    mk    = '{-1, -1};
    mtot  = '{0, 0};
    mdone = '{1'b0, 1'b0};
    mpat  = '{'0, '0};
    test_reset();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
`ifdef PATTERN_SERIALIZER_LOOP_EN
    test_loop_stop();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
